// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key schedule tables, widths, state type and rotate helper.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 56;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;

  // Entries are 1-based DES bit numbers, listed from output bit 1 downwards.
  localparam int PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [HALF_W-1:0] rot28(input logic [HALF_W-1:0] x,
                                              input logic left,
                                              input logic two);
    logic [HALF_W-1:0] r;
    case ({left, two})
      2'b10:   r = {x[HALF_W-2:0], x[HALF_W-1]};
      2'b11:   r = {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
      2'b00:   r = {x[0], x[HALF_W-1:1]};
      default: r = {x[1:0], x[HALF_W-1:2]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - DES permuted choice 2: 56-bit C/D to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] subkey
);

  // cd[55] is C/D bit 1 and subkey[47] is subkey bit 1.
  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
    assign subkey[SUBKEY_W-1-i] = cd[CD_W-PC2[i]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - Iterative DES key schedule issuing 16 subkeys over valid/ready.
module des_key_schedule
  import des_pkg::*;
#(
  parameter bit OUT_GATE = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_key_valid,
  output logic                o_key_ready,
  input  logic [KEY_W-1:0]    i_key,
  input  logic                i_decrypt,
  input  logic                i_flush,
  output logic [SUBKEY_W-1:0] o_subkey,
  output logic                o_subkey_valid,
  input  logic                i_subkey_ready,
  output logic [3:0]          o_round,
  output logic                o_last
);

  state_t                state, state_next;
  logic [CD_W-1:0]       cd, cd_pc1, cd_first, cd_step;
  logic [3:0]            round;
  logic                  decrypt;
  logic [3:0]            sh_idx;
  logic                  sh_two;
  logic                  accept, xfer;
  logic [SUBKEY_W-1:0]   pc2_out;

  // Parity bits (DES bits 8,16,...,64) never appear in PC1 and drop out here.
  for (genvar i = 0; i < CD_W; i++) begin : g_pc1
    assign cd_pc1[CD_W-1-i] = i_key[KEY_W-PC1[i]];
  end

  assign accept = (state == IDLE) && i_key_valid && !i_flush;
  assign xfer   = (state == RUN) && i_subkey_ready && !i_flush;

  // Decrypt starts from C0D0, which equals C16D16 since the shifts total 28.
  assign cd_first = i_decrypt ? cd_pc1
                  : {rot28(cd_pc1[CD_W-1:HALF_W], 1'b1, 1'b0),
                     rot28(cd_pc1[HALF_W-1:0],    1'b1, 1'b0)};

  assign sh_idx  = decrypt ? (4'd15 - round) : (round + 4'd1);
  assign sh_two  = (SHIFT[sh_idx] == 2);
  assign cd_step = {rot28(cd[CD_W-1:HALF_W], !decrypt, sh_two),
                    rot28(cd[HALF_W-1:0],    !decrypt, sh_two)};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        if (i_flush) begin
          state_next = IDLE;
        end else if (xfer && (round == 4'd15)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_key_ready    = (state == IDLE) && !i_rst;
    o_subkey_valid = (state == RUN);
    o_last         = (state == RUN) && (round == 4'd15);
    o_round        = round;
    o_subkey       = (OUT_GATE && (state != RUN)) ? '0 : pc2_out;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cd      <= '0;
      round   <= '0;
      decrypt <= 1'b0;
    end else if (i_flush) begin
      cd    <= '0;
      round <= '0;
    end else if (accept) begin
      cd      <= cd_first;
      round   <= '0;
      decrypt <= i_decrypt;
    end else if (xfer) begin
      if (round == 4'd15) begin
        round <= '0;
      end else begin
        round <= round + 4'd1;
        cd    <= cd_step;
      end
    end
  end

  des_pc2 u_pc2 (
    .cd     (cd),
    .subkey (pc2_out)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - Directed-vector bench for des_key_schedule.
module tb_des_key_schedule;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_key_valid;
  logic        o_key_ready;
  logic [63:0] i_key;
  logic        i_decrypt;
  logic        i_flush;
  logic [47:0] o_subkey;
  logic        o_subkey_valid;
  logic        i_subkey_ready;
  logic [3:0]  o_round;
  logic        o_last;

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [63:0] KEY   = 64'h133457799BBCDFF1;
  localparam logic [63:0] OTHER = 64'h0E329232EA6D0D73;

  // Published subkeys K1..K16 for KEY.
  logic [47:0] kexp [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  always #5 i_clk = ~i_clk;

  des_key_schedule #(.OUT_GATE(1'b1)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_key_valid    (i_key_valid),
    .o_key_ready    (o_key_ready),
    .i_key          (i_key),
    .i_decrypt      (i_decrypt),
    .i_flush        (i_flush),
    .o_subkey       (o_subkey),
    .o_subkey_valid (o_subkey_valid),
    .i_subkey_ready (i_subkey_ready),
    .o_round        (o_round),
    .o_last         (o_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 64'(o_subkey_valid), 64'd0);
    check({tag, "_subkey"}, 64'(o_subkey), 64'd0);
    check({tag, "_round"}, 64'(o_round), 64'd0);
    check({tag, "_last"}, 64'(o_last), 64'd0);
    check({tag, "_key_ready"}, 64'(o_key_ready), 64'd1);
  endtask

  // Accept a key, walk the schedule and compare every presented subkey.
  // abort_at >= 0 issues a flush (or reset) while that issue index is presented.
  task automatic run_sched(input logic [63:0] key, input bit dec,
                           input int stall_at, input int stall_n,
                           input int inject_at, input int abort_at, input bit abort_rst);
    int idx, cyc, stalled;
    bit injected;
    logic [47:0] exp;
    idx = 0; cyc = 0; stalled = 0; injected = 1'b0;
    check("accept_ready", 64'(o_key_ready), 64'd1);
    i_key = key; i_decrypt = dec; i_key_valid = 1'b1; i_subkey_ready = 1'b1;
    tick();
    i_key_valid = 1'b0; i_key = '0; i_decrypt = ~dec;
    cyc = 1;
    check("valid_rise", 64'(o_subkey_valid), 64'd1);
    while (idx < 16 && cyc < 60) begin
      exp = dec ? kexp[15-idx] : kexp[idx];
      check("subkey", 64'(o_subkey), 64'(exp));
      check("round", 64'(o_round), 64'(idx));
      check("last", 64'(o_last), (idx == 15) ? 64'd1 : 64'd0);
      check("busy_key_ready", 64'(o_key_ready), 64'd0);
      i_key_valid = 1'b0;
      if (idx == inject_at && !injected) begin
        i_key_valid = 1'b1; i_key = OTHER; injected = 1'b1;
      end
      if (idx == abort_at) begin
        i_subkey_ready = 1'b1;
        if (abort_rst) i_rst = 1'b1; else i_flush = 1'b1;
        tick();
        i_rst = 1'b0; i_flush = 1'b0; i_key_valid = 1'b0; i_subkey_ready = 1'b0;
        #1;
        check_idle_outputs(abort_rst ? "after_rst" : "after_flush");
        return;
      end
      if (idx == stall_at && stalled < stall_n) begin
        i_subkey_ready = 1'b0;
        stalled++;
      end else begin
        i_subkey_ready = 1'b1;
        idx++;
      end
      tick();
      cyc++;
    end
    i_key_valid = 1'b0;
    i_subkey_ready = 1'b0;
    check("issued_count", 64'(idx), 64'd16);
    check("end_valid", 64'(o_subkey_valid), 64'd0);
    check("end_key_ready", 64'(o_key_ready), 64'd1);
    check("schedule_cycles", 64'(cyc), 64'(17 + stall_n));
  endtask

  initial begin
    i_rst = 1'b1; i_key_valid = 1'b0; i_key = '0; i_decrypt = 1'b0;
    i_flush = 1'b0; i_subkey_ready = 1'b0;
    tick();
    tick();
    check("rst_key_ready", 64'(o_key_ready), 64'd0);
    check("rst_valid", 64'(o_subkey_valid), 64'd0);
    check("rst_subkey", 64'(o_subkey), 64'd0);
    check("rst_round", 64'(o_round), 64'd0);
    check("rst_last", 64'(o_last), 64'd0);
    i_rst = 1'b0;
    #1;
    check("post_rst_key_ready", 64'(o_key_ready), 64'd1);
    tick();

    run_sched(KEY, 1'b0, -1, 0, -1, -1, 1'b0);
    run_sched(KEY, 1'b1, -1, 0, -1, -1, 1'b0);
    run_sched(KEY ^ 64'h0101010101010101, 1'b0, -1, 0, -1, -1, 1'b0);
    run_sched(KEY, 1'b0, 4, 3, -1, -1, 1'b0);
    run_sched(KEY, 1'b0, -1, 0, 7, 9, 1'b0);

    // A flush in IDLE must block the key offered in the same cycle.
    i_flush = 1'b1; i_key_valid = 1'b1; i_key = KEY; i_decrypt = 1'b0;
    tick();
    i_flush = 1'b0; i_key_valid = 1'b0;
    check("idle_flush_valid", 64'(o_subkey_valid), 64'd0);
    check("idle_flush_key_ready", 64'(o_key_ready), 64'd1);

    run_sched(KEY, 1'b0, -1, 0, -1, 3, 1'b1);
    run_sched(KEY, 1'b0, -1, 0, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
